sysreg_access_ctrl: RTL and testbench

//  Sequences all system-register accesses. Arbitrates MFS reads (from the Read stage) and
//  MTS writes (from Writeback) onto the single sysreg port, checks privilege before issue,

---
 rtl/sysreg_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sysreg_access_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysreg_access_ctrl.sv
// sysreg_access_ctrl
//   Sequences every system-register access. MFS reads (Read stage) and MTS
//   writes (Writeback) are arbitrated round-robin onto the single sysreg
//   port. Privilege is checked before issue. A level req/ack handshake with
//   a timeout runs on the sysreg port, and exactly one response is returned
//   per accepted request. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cur_plevel                   current core privilege level
//   rd_req_*                     MFS request (valid/ready, group, regnum, plevel, tag)
//   wr_req_*                     MTS request (valid/ready, group, regnum, plevel, data)
//   sreg_en/we/group/regnum/
//   sreg_plevel/wdata            sysreg access request, held while en=1
//   sreg_ack/err/rdata           sysreg completion, err/rdata qualified by ack
//   rsp_valid/ready              response handshake
//   rsp_is_wr/tag/data/fault     response payload (fault: 0 ok, 1 priv, 2 bus, 3 timeout)
//   busy                         controller is not idle; stalls the Read stage
module sysreg_access_ctrl #(
    parameter int REG_WIDTH   = 64,
    parameter int TAG_WIDTH   = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cur_plevel,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [4:0]           rd_req_group,
    input  logic [2:0]           rd_req_regnum,
    input  logic [1:0]           rd_req_plevel,
    input  logic [TAG_WIDTH-1:0] rd_req_tag,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [4:0]           wr_req_group,
    input  logic [2:0]           wr_req_regnum,
    input  logic [1:0]           wr_req_plevel,
    input  logic [REG_WIDTH-1:0] wr_req_data,
    output logic                 sreg_en,
    output logic                 sreg_we,
    output logic [4:0]           sreg_group,
    output logic [2:0]           sreg_regnum,
    output logic [1:0]           sreg_plevel,
    output logic [REG_WIDTH-1:0] sreg_wdata,
    input  logic                 sreg_ack,
    input  logic                 sreg_err,
    input  logic [REG_WIDTH-1:0] sreg_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_is_wr,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [REG_WIDTH-1:0] rsp_data,
    output logic [1:0]           rsp_fault,
    output logic                 busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] FAULT_OK      = 2'd0;
    localparam logic [1:0] FAULT_PRIV    = 2'd1;
    localparam logic [1:0] FAULT_BUS     = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {RR_RD, RR_WR} side_t;

    state_t               state, state_next;
    side_t                rr_last;
    logic [CNT_W-1:0]     cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 grant_rd, grant_wr, accept;
    logic [1:0]           sel_plevel;
    logic                 priv_fault, timeout_hit, req_done;

    // Grant only in IDLE; on a tie the side not granted last wins. Reset
    // suppresses grants so nothing is accepted in a cycle that is being dropped.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE && !rst) begin
            if (rd_req_valid && (!wr_req_valid || rr_last == RR_WR))
                grant_rd = 1'b1;
            else if (wr_req_valid)
                grant_wr = 1'b1;
        end
    end

    assign rd_req_ready = grant_rd;
    assign wr_req_ready = grant_wr;
    assign accept       = grant_rd | grant_wr;
    assign sel_plevel   = grant_rd ? rd_req_plevel : wr_req_plevel;
    assign priv_fault   = sel_plevel > cur_plevel;
    assign timeout_hit  = cnt == CNT_W'(TIMEOUT_CYC - 1);
    // An ack in the timeout cycle still counts as a normal completion.
    assign req_done     = sreg_ack | timeout_hit;
    assign busy         = state != IDLE;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = priv_fault ? RESP : REQ;
            REQ:     if (req_done)  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last     <= RR_WR;
            cnt         <= '0;
            tag_q       <= '0;
            sreg_en     <= 1'b0;
            sreg_we     <= 1'b0;
            sreg_group  <= '0;
            sreg_regnum <= '0;
            sreg_plevel <= '0;
            sreg_wdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_is_wr   <= 1'b0;
            rsp_tag     <= '0;
            rsp_data    <= '0;
            rsp_fault   <= FAULT_OK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rr_last <= grant_rd ? RR_RD : RR_WR;
                        tag_q   <= grant_rd ? rd_req_tag : '0;
                        if (priv_fault) begin
                            // Never reaches the sysreg port.
                            rsp_valid <= 1'b1;
                            rsp_is_wr <= grant_wr;
                            rsp_tag   <= grant_rd ? rd_req_tag : '0;
                            rsp_data  <= '0;
                            rsp_fault <= FAULT_PRIV;
                        end else begin
                            sreg_en     <= 1'b1;
                            sreg_we     <= grant_wr;
                            sreg_group  <= grant_rd ? rd_req_group  : wr_req_group;
                            sreg_regnum <= grant_rd ? rd_req_regnum : wr_req_regnum;
                            sreg_plevel <= sel_plevel;
                            sreg_wdata  <= grant_wr ? wr_req_data : '0;
                            cnt         <= '0;
                        end
                    end
                end
                REQ: begin
                    if (req_done) begin
                        sreg_en     <= 1'b0;
                        sreg_we     <= 1'b0;
                        sreg_group  <= '0;
                        sreg_regnum <= '0;
                        sreg_plevel <= '0;
                        sreg_wdata  <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_is_wr   <= sreg_we;
                        rsp_tag     <= tag_q;
                        if (sreg_ack) begin
                            rsp_fault <= sreg_err ? FAULT_BUS : FAULT_OK;
                            rsp_data  <= (!sreg_we && !sreg_err) ? sreg_rdata : '0;
                        end else begin
                            rsp_fault <= FAULT_TIMEOUT;
                            rsp_data  <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_is_wr <= 1'b0;
                        rsp_tag   <= '0;
                        rsp_data  <= '0;
                        rsp_fault <= FAULT_OK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysreg_access_ctrl.sv
// Directed testbench for sysreg_access_ctrl.
module tb_sysreg_access_ctrl;

    localparam int RW = 64;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cur_plevel;
    logic          rd_req_valid, rd_req_ready;
    logic [4:0]    rd_req_group;
    logic [2:0]    rd_req_regnum;
    logic [1:0]    rd_req_plevel;
    logic [TW-1:0] rd_req_tag;
    logic          wr_req_valid, wr_req_ready;
    logic [4:0]    wr_req_group;
    logic [2:0]    wr_req_regnum;
    logic [1:0]    wr_req_plevel;
    logic [RW-1:0] wr_req_data;
    logic          sreg_en, sreg_we;
    logic [4:0]    sreg_group;
    logic [2:0]    sreg_regnum;
    logic [1:0]    sreg_plevel;
    logic [RW-1:0] sreg_wdata;
    logic          sreg_ack, sreg_err;
    logic [RW-1:0] sreg_rdata;
    logic          rsp_valid, rsp_ready, rsp_is_wr;
    logic [TW-1:0] rsp_tag;
    logic [RW-1:0] rsp_data;
    logic [1:0]    rsp_fault;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int en_cycles = 0;
    bit grant_q[$];   // 0 = read grant, 1 = write grant

    sysreg_access_ctrl #(.REG_WIDTH(RW), .TAG_WIDTH(TW), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst), .cur_plevel(cur_plevel),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_group(rd_req_group), .rd_req_regnum(rd_req_regnum),
        .rd_req_plevel(rd_req_plevel), .rd_req_tag(rd_req_tag),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_group(wr_req_group), .wr_req_regnum(wr_req_regnum),
        .wr_req_plevel(wr_req_plevel), .wr_req_data(wr_req_data),
        .sreg_en(sreg_en), .sreg_we(sreg_we), .sreg_group(sreg_group),
        .sreg_regnum(sreg_regnum), .sreg_plevel(sreg_plevel), .sreg_wdata(sreg_wdata),
        .sreg_ack(sreg_ack), .sreg_err(sreg_err), .sreg_rdata(sreg_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(rsp_is_wr),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_fault(rsp_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count cycles with sreg_en high and log every accepted request.
    always @(posedge clk) begin
        if (sreg_en) en_cycles++;
        if (!rst && rd_req_valid && rd_req_ready) grant_q.push_back(1'b0);
        if (!rst && wr_req_valid && wr_req_ready) grant_q.push_back(1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rd_req_valid = 0; rd_req_group = 0; rd_req_regnum = 0; rd_req_plevel = 0; rd_req_tag = 0;
        wr_req_valid = 0; wr_req_group = 0; wr_req_regnum = 0; wr_req_plevel = 0; wr_req_data = 0;
        sreg_ack = 0; sreg_err = 0; sreg_rdata = 0; rsp_ready = 0;
    endtask

    task automatic do_reset;
        rst = 1; tick; tick; rst = 0;
    endtask

    // Consume the pending response and confirm the controller returns to IDLE.
    task automatic finish_rsp(input string name);
        rsp_ready = 1; tick; rsp_ready = 0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL %s_rsp_drop: got %b want 0", name, rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_idle: busy got %b want 0", name, busy); end
    endtask

    task automatic test_reset;
        idle_inputs; cur_plevel = 0;
        rst = 1; tick; tick;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (sreg_en !== 1'b0) begin fails++; $display("FAIL reset_sreg_en: got %b want 0", sreg_en); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if ({rsp_fault, rsp_data, rsp_tag, sreg_we, sreg_wdata} !== '0) begin fails++; $display("FAIL reset_fields: outputs not all zero"); end
        rst = 0; tick;
        tests++; if ({rd_req_ready, wr_req_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {rd_req_ready, wr_req_ready}); end
    endtask

    task automatic test_read;
        int en0;
        en0 = en_cycles;
        cur_plevel = 0;
        rd_req_valid = 1; rd_req_group = 3; rd_req_regnum = 2; rd_req_plevel = 0; rd_req_tag = 7;
        #1;
        tests++; if ({rd_req_ready, wr_req_ready} !== 2'b10) begin fails++; $display("FAIL read_ready: got %b want 10", {rd_req_ready, wr_req_ready}); end
        tick; rd_req_valid = 0;
        tests++; if ({sreg_en, sreg_we, sreg_group, sreg_regnum, sreg_plevel} !== {1'b1, 1'b0, 5'd3, 3'd2, 2'd0}) begin fails++;
            $display("FAIL read_issue: en=%b we=%b grp=%0d num=%0d pl=%0d want 1 0 3 2 0", sreg_en, sreg_we, sreg_group, sreg_regnum, sreg_plevel); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL read_busy: got %b want 1", busy); end
        tick;
        sreg_ack = 1; sreg_rdata = 64'hDEAD;
        tick;
        sreg_ack = 0; sreg_rdata = 0;
        tests++; if ({rsp_valid, rsp_is_wr, rsp_tag, rsp_fault} !== {1'b1, 1'b0, 5'd7, 2'd0}) begin fails++;
            $display("FAIL read_rsp: valid=%b is_wr=%b tag=%0d fault=%0d want 1 0 7 0", rsp_valid, rsp_is_wr, rsp_tag, rsp_fault); end
        tests++; if (rsp_data !== 64'hDEAD) begin fails++; $display("FAIL read_data: got %h want dead", rsp_data); end
        tests++; if (sreg_en !== 1'b0) begin fails++; $display("FAIL read_en_drop: got %b want 0", sreg_en); end
        tests++; if (en_cycles - en0 !== 2) begin fails++; $display("FAIL read_en_len: got %0d want 2", en_cycles - en0); end
        finish_rsp("read");
    endtask

    task automatic test_write;
        cur_plevel = 3;
        wr_req_valid = 1; wr_req_group = 5; wr_req_regnum = 1; wr_req_plevel = 1; wr_req_data = 64'h1234;
        #1;
        tests++; if ({rd_req_ready, wr_req_ready} !== 2'b01) begin fails++; $display("FAIL write_ready: got %b want 01", {rd_req_ready, wr_req_ready}); end
        tick; wr_req_valid = 0;
        tests++; if ({sreg_en, sreg_we, sreg_group, sreg_plevel} !== {1'b1, 1'b1, 5'd5, 2'd1}) begin fails++;
            $display("FAIL write_issue: en=%b we=%b grp=%0d pl=%0d want 1 1 5 1", sreg_en, sreg_we, sreg_group, sreg_plevel); end
        tests++; if (sreg_wdata !== 64'h1234) begin fails++; $display("FAIL write_wdata: got %h want 1234", sreg_wdata); end
        sreg_ack = 1; sreg_err = 1; sreg_rdata = 64'hFFFF;
        tick;
        sreg_ack = 0; sreg_err = 0; sreg_rdata = 0;
        tests++; if ({rsp_valid, rsp_is_wr, rsp_tag, rsp_fault} !== {1'b1, 1'b1, 5'd0, 2'd2}) begin fails++;
            $display("FAIL write_rsp: valid=%b is_wr=%b tag=%0d fault=%0d want 1 1 0 2", rsp_valid, rsp_is_wr, rsp_tag, rsp_fault); end
        tests++; if (rsp_data !== 64'h0) begin fails++; $display("FAIL write_data: got %h want 0", rsp_data); end
        finish_rsp("write");
    endtask

    task automatic test_privilege;
        int en0;
        en0 = en_cycles;
        cur_plevel = 1;
        rd_req_valid = 1; rd_req_group = 2; rd_req_regnum = 4; rd_req_plevel = 2; rd_req_tag = 4;
        tick; rd_req_valid = 0;
        tests++; if ({rsp_valid, rsp_is_wr, rsp_tag, rsp_fault} !== {1'b1, 1'b0, 5'd4, 2'd1}) begin fails++;
            $display("FAIL priv_rsp: valid=%b is_wr=%b tag=%0d fault=%0d want 1 0 4 1", rsp_valid, rsp_is_wr, rsp_tag, rsp_fault); end
        tests++; if (rsp_data !== 64'h0) begin fails++; $display("FAIL priv_data: got %h want 0", rsp_data); end
        tick;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL priv_hold: got %b want 1", rsp_valid); end
        finish_rsp("priv");
        tests++; if (en_cycles - en0 !== 0) begin fails++; $display("FAIL priv_no_en: sreg_en high %0d cycles want 0", en_cycles - en0); end
        cur_plevel = 0;
    endtask

    task automatic test_timeout;
        int en0;
        // No ack at all.
        en0 = en_cycles;
        rd_req_valid = 1; rd_req_group = 1; rd_req_regnum = 1; rd_req_plevel = 0; rd_req_tag = 3;
        tick; rd_req_valid = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) tick;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL timeout_wait: rsp_valid got %b want 1", rsp_valid); end
        tests++; if ({rsp_fault, rsp_tag} !== {2'd3, 5'd3}) begin fails++; $display("FAIL timeout_fault: fault=%0d tag=%0d want 3 3", rsp_fault, rsp_tag); end
        tests++; if (en_cycles - en0 !== 15) begin fails++; $display("FAIL timeout_en_len: got %0d want 15", en_cycles - en0); end
        finish_rsp("timeout");
        // Ack arriving in the last REQ cycle wins over the timeout.
        en0 = en_cycles;
        rd_req_valid = 1; rd_req_tag = 6;
        tick; rd_req_valid = 0;
        for (int i = 0; i < 14; i++) tick;
        tests++; if (sreg_en !== 1'b1) begin fails++; $display("FAIL late_ack_en: got %b want 1", sreg_en); end
        sreg_ack = 1; sreg_rdata = 64'h55;
        tick;
        sreg_ack = 0; sreg_rdata = 0;
        tests++; if ({rsp_valid, rsp_fault, rsp_tag} !== {1'b1, 2'd0, 5'd6}) begin fails++;
            $display("FAIL late_ack_rsp: valid=%b fault=%0d tag=%0d want 1 0 6", rsp_valid, rsp_fault, rsp_tag); end
        tests++; if (rsp_data !== 64'h55) begin fails++; $display("FAIL late_ack_data: got %h want 55", rsp_data); end
        tests++; if (en_cycles - en0 !== 15) begin fails++; $display("FAIL late_ack_en_len: got %0d want 15", en_cycles - en0); end
        finish_rsp("late_ack");
    endtask

    task automatic test_arbitration;
        int base;
        int both_hi;
        idle_inputs; do_reset;
        base = grant_q.size();
        both_hi = 0;
        rd_req_valid = 1; rd_req_tag = 1; rd_req_group = 7;
        wr_req_valid = 1; wr_req_group = 8; wr_req_data = 64'hAA;
        rsp_ready = 1;
        for (int i = 0; i < 30; i++) begin
            sreg_ack = sreg_en;
            #1;
            if (rd_req_ready && wr_req_ready) both_hi++;
            tick;
        end
        rd_req_valid = 0; wr_req_valid = 0;
        for (int i = 0; i < 5; i++) begin sreg_ack = sreg_en; tick; end
        sreg_ack = 0; rsp_ready = 0;
        tests++; if (both_hi !== 0) begin fails++; $display("FAIL arb_exclusive: both ready in %0d cycles want 0", both_hi); end
        tests++; if (grant_q.size() - base < 6) begin fails++; $display("FAIL arb_count: got %0d grants want >= 6", grant_q.size() - base); end
        else begin
            for (int i = 0; i < 6; i++) begin
                tests++; if (grant_q[base + i] !== bit'(i % 2)) begin fails++;
                    $display("FAIL arb_order_%0d: got %0d want %0d (0=rd 1=wr)", i, grant_q[base + i], i % 2); end
            end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arb_drain: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int nq;
        idle_inputs;
        rd_req_valid = 1; rd_req_group = 2; rd_req_regnum = 3; rd_req_tag = 9;
        tick; rd_req_valid = 0;
        sreg_ack = 1; sreg_rdata = 64'hBEEF;
        tick;
        sreg_ack = 0; sreg_rdata = 0;
        rd_req_valid = 1; wr_req_valid = 1;
        nq = grant_q.size();
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if ({rsp_valid, rsp_is_wr, rsp_tag, rsp_fault, rsp_data} !== {1'b1, 1'b0, 5'd9, 2'd0, 64'hBEEF}) begin fails++;
                $display("FAIL bp_hold_%0d: valid=%b tag=%0d fault=%0d data=%h want 1 9 0 beef", i, rsp_valid, rsp_tag, rsp_fault, rsp_data); end
            tests++; if ({rd_req_ready, wr_req_ready} !== 2'b00) begin fails++; $display("FAIL bp_ready_%0d: got %b want 00", i, {rd_req_ready, wr_req_ready}); end
            tick;
        end
        rsp_ready = 1;
        #1;
        tests++; if ({rd_req_ready, wr_req_ready} !== 2'b00) begin fails++; $display("FAIL bp_hs_ready: got %b want 00", {rd_req_ready, wr_req_ready}); end
        tick; rsp_ready = 0;
        tests++; if (grant_q.size() !== nq) begin fails++; $display("FAIL bp_no_grant: got %0d grants want %0d", grant_q.size(), nq); end
        tests++; if ({busy, rsp_valid} !== 2'b00) begin fails++; $display("FAIL bp_idle: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
        #1;
        // Last grant was the read, so the write now wins the tie.
        tests++; if ({rd_req_ready, wr_req_ready} !== 2'b01) begin fails++; $display("FAIL bp_next_rr: got %b want 01", {rd_req_ready, wr_req_ready}); end
        rd_req_valid = 0; wr_req_valid = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        idle_inputs;
        rd_req_valid = 1; rd_req_tag = 2;
        tick; rd_req_valid = 0;
        tests++; if (sreg_en !== 1'b1) begin fails++; $display("FAIL rstmid_req: sreg_en got %b want 1", sreg_en); end
        rst = 1; tick; rst = 0;
        tests++; if ({busy, sreg_en, rsp_valid} !== 3'b000) begin fails++;
            $display("FAIL rstmid_clear: busy=%b en=%b rsp_valid=%b want 0 0 0", busy, sreg_en, rsp_valid); end
        sreg_ack = 1; sreg_rdata = 64'h77;
        tick;
        sreg_ack = 0; sreg_rdata = 0;
        for (int i = 0; i < 3; i++) begin
            tests++; if ({busy, rsp_valid} !== 2'b00) begin fails++; $display("FAIL rstmid_stray_ack_%0d: busy=%b rsp_valid=%b want 0 0", i, busy, rsp_valid); end
            tick;
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs;
        cur_plevel = 0;
        test_reset;
        test_read;
        test_write;
        test_privilege;
        test_timeout;
        test_arbitration;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
